alu_cmd_responder: RTL
======================

ALU_CMD_RESPONDER -- requirements
Module: alu_cmd_responder

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port start, input, 1, initiator request; held high until done is seen.
REQ-004 SHALL have port op, input, 3, operation code (operation_t encoding).
REQ-005 SHALL have port A, input, 8, unsigned operand A.
REQ-006 SHALL have port B, input, 8, unsigned operand B.
REQ-007 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-008 SHALL have port result, output, 16, result; valid while done=1, held until the next completion.
REQ-009 SHALL have port busy, output, 1, high from the accept edge until return to IDLE.
REQ-010 SHALL have port err, output, 1, illegal-op flag, coincident with done.

Function
REQ-011 SHALL use op encoding no_op=000, add_op=001, and_op=010, xor_op=011, mul_op=100; 101-111 illegal.
REQ-012 SHALL implement FSM states IDLE, EXEC, DONE, WAIT_LOW.
REQ-013 SHALL accept in IDLE at edge N when start=1 and op is legal and not no_op: capture A, B, op, go to EXEC.
REQ-014 SHALL ignore later A/B/op changes until the next accept.
REQ-015 SHALL treat no_op as a non-request: stay IDLE, no done.
REQ-016 SHALL complete add/and/xor with done=1 in the cycle after edge N+1, and mul_op after edge N+3.
REQ-017 SHALL compute add as 9-bit A+B zero-extended to 16; and/xor as 8-bit results zero-extended; mul as full 16-bit A*B.
REQ-018 SHALL drive done high for exactly one cycle (state DONE), then go to WAIT_LOW.
REQ-019 SHALL stay in WAIT_LOW while start=1 and return to IDLE on the first sampled start=0; no new accept until then.
REQ-020 SHALL abort when start falls in EXEC: go to IDLE, no done, result unchanged, pipeline flushed.
REQ-021 SHALL set busy=1 in EXEC, DONE and WAIT_LOW.

Reset
REQ-022 SHALL on reset=1 at any edge, including mid-EXEC: state=IDLE, done=0, err=0, busy=0, result=16'h0000, mul pipeline cleared.
REQ-023 SHALL give reset priority over start; a start held high through reset release is accepted at the first edge with reset=0.

Configuration
REQ-024 SHALL, with ALU_RESP_ILLEGAL_OP_EN defined, treat op 101-111 as an accepted request: done=1 and err=1 after edge N+1, result=16'hDEAD, then normal DONE/WAIT_LOW flow.
REQ-025 SHALL, without ALU_RESP_ILLEGAL_OP_EN, treat op 101-111 as no_op, with err tied to 0.

Structure
REQ-026 SHALL take operation_t, op encodings, latency constants (ALU_LAT=1, MUL_LAT=3) and the 16'hDEAD error pattern from tinyalu_pkg.
REQ-027 SHALL implement the multiplier as sub-module alu_mul_pipe: 3-stage, valid-tagged, synchronous clear on reset or abort.

Verification
REQ-028 SHALL cover: A=8'hFF, B=8'h01, add_op, start held -> done one cycle after edge N+1, result=16'h0100, err=0.
REQ-029 SHALL cover: A=8'hFF, B=8'hFF, mul_op -> done after edge N+3, result=16'hFE01; A/B changed during EXEC do not affect the result.
REQ-030 SHALL cover: xor_op A=8'hA5, B=8'h0F, start kept high 5 cycles after done -> result=16'h00AA, single done pulse, busy high until start falls.
REQ-031 SHALL cover: mul_op accepted, reset asserted at edge N+2 -> no done, result=16'h0000, IDLE; the next add 3+4 gives result=16'h0007.
REQ-032 SHALL cover: op=3'b110 -> with macro: done, err=1, result=16'hDEAD; without: no done for 10 cycles, busy=0.
REQ-033 SHALL cover: mul_op accepted, start dropped at edge N+1 -> no done, busy=0 next cycle; the next and_op 8'hF0&8'h3C gives result=16'h0030.

Source files
------------

// File: rtl/tinyalu_pkg.sv
// tinyalu_pkg: shared op encodings, FSM states, latencies and result helpers
// for the command-driven ALU responder.
package tinyalu_pkg;

    // Operation codes; 101-111 are not named and count as illegal.
    typedef enum logic [2:0] {
        no_op  = 3'b000,
        add_op = 3'b001,
        and_op = 3'b010,
        xor_op = 3'b011,
        mul_op = 3'b100
    } operation_t;

    // Responder control states.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EXEC     = 2'd1,
        DONE     = 2'd2,
        WAIT_LOW = 2'd3
    } state_t;

    // Edges spent in EXEC before completion, counted from the accept edge.
    localparam int ALU_LAT = 1;
    localparam int MUL_LAT = 3;

    // Result returned for an accepted illegal opcode.
    localparam logic [15:0] ERR_PATTERN = 16'hDEAD;

    // True for the five named encodings (no_op included).
    function automatic logic isLegalOp(input logic [2:0] code);
        return (code <= 3'b100);
    endfunction

endpackage

// File: rtl/alu_cmd_responder_if.sv
// alu_cmd_responder_if: request/response bundle between an initiator (master)
// and the ALU responder (slave).
interface alu_cmd_responder_if;
    logic        start;
    logic [2:0]  op;
    logic [7:0]  A;
    logic [7:0]  B;
    logic        done;
    logic [15:0] result;
    logic        busy;
    logic        err;

    modport master (output start, op, A, B, input done, result, busy, err);
    modport slave  (input start, op, A, B, output done, result, busy, err);
endinterface

// File: rtl/alu_mul_pipe.sv
// alu_mul_pipe: three-stage valid-tagged 8x8 multiplier. The clear input
// flushes every stage (data and valid) on the next rising edge.
module alu_mul_pipe
    import tinyalu_pkg::*;
(
    input  logic        clk,
    input  logic        clear_i,
    input  logic        in_valid_i,
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic        out_valid_o,
    output logic [15:0] product_o
);
    logic        v1Q, v2Q, v3Q;
    logic [7:0]  a1Q, b1Q;
    logic [15:0] p2Q, p3Q;

    // Operand capture, multiply, and output register stages; clear wipes them all.
    always_ff @(posedge clk) begin
        if (clear_i) begin
            v1Q <= 1'b0;
            v2Q <= 1'b0;
            v3Q <= 1'b0;
            a1Q <= 8'h00;
            b1Q <= 8'h00;
            p2Q <= 16'h0000;
            p3Q <= 16'h0000;
        end else begin
            v1Q <= in_valid_i;
            a1Q <= a_i;
            b1Q <= b_i;
            v2Q <= v1Q;
            p2Q <= 16'(a1Q) * 16'(b1Q);
            v3Q <= v2Q;
            p3Q <= p2Q;
        end
    end

    assign out_valid_o = v3Q;
    assign product_o   = p3Q;

endmodule

// File: rtl/alu_cmd_responder.sv
// alu_cmd_responder: accepts one ALU command per start handshake, returns a
// one-cycle done pulse with the result, then waits for start to drop.
// Optional feature macro: ALU_RESP_ILLEGAL_OP_EN -- when defined, opcodes
// 101-111 are accepted and answered with err=1 and result 16'hDEAD; when
// undefined they are ignored like no_op and err stays 0.
module alu_cmd_responder
    import tinyalu_pkg::*;
(
    input logic               clk,
    input logic               reset,
    alu_cmd_responder_if.slave bus
);
    state_t      stateQ;
    operation_t  opQ;
    logic [7:0]  aQ, bQ;
    logic        illegalQ;
    logic [1:0]  cntQ;
    logic        doneQ, errQ, busyQ;
    logic [15:0] resultQ;
    logic [15:0] resultD;

    operation_t  opIn;
    logic        illegalReq;
    logic        acceptReq;
    logic        abortReq;
    logic        execComplete;
    logic        mulInValid;
    logic        mulClear;
    logic        mulValid;
    logic [15:0] mulProduct;

    assign opIn = operation_t'(bus.op);

`ifdef ALU_RESP_ILLEGAL_OP_EN
    assign illegalReq = !isLegalOp(bus.op);
`else
    assign illegalReq = 1'b0;
`endif

    assign acceptReq  = bus.start && ((isLegalOp(bus.op) && (opIn != no_op)) || illegalReq);
    assign abortReq   = (stateQ == EXEC) && !bus.start;
    assign mulInValid = (stateQ == IDLE) && acceptReq && (opIn == mul_op);
    assign mulClear   = reset || abortReq;

    // Multiplies receive operands straight from the bus on the accept edge so
    // the product is ready exactly MUL_LAT edges later.
    alu_mul_pipe u_mul (
        .clk         (clk),
        .clear_i     (mulClear),
        .in_valid_i  (mulInValid),
        .a_i         (bus.A),
        .b_i         (bus.B),
        .out_valid_o (mulValid),
        .product_o   (mulProduct)
    );

    assign execComplete = (opQ == mul_op && !illegalQ) ? mulValid
                                                        : (cntQ == 2'(ALU_LAT));

    // Selects the result for the captured command.
    always_comb begin
        resultD = 16'h0000;
        if (illegalQ) begin
            resultD = ERR_PATTERN;
        end else begin
            case (opQ)
                add_op:  resultD = {7'b0, {1'b0, aQ} + {1'b0, bQ}};
                and_op:  resultD = {8'h00, aQ & bQ};
                xor_op:  resultD = {8'h00, aQ ^ bQ};
                mul_op:  resultD = mulProduct;
                default: resultD = 16'h0000;
            endcase
        end
    end

    // Handshake FSM with registered done/err/busy/result; a falling start in
    // EXEC aborts without touching the held result.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ   <= IDLE;
            opQ      <= no_op;
            aQ       <= 8'h00;
            bQ       <= 8'h00;
            illegalQ <= 1'b0;
            cntQ     <= 2'd0;
            doneQ    <= 1'b0;
            errQ     <= 1'b0;
            busyQ    <= 1'b0;
            resultQ  <= 16'h0000;
        end else begin
            doneQ <= 1'b0;
            errQ  <= 1'b0;
            case (stateQ)
                IDLE: begin
                    if (acceptReq) begin
                        stateQ   <= EXEC;
                        busyQ    <= 1'b1;
                        opQ      <= opIn;
                        aQ       <= bus.A;
                        bQ       <= bus.B;
                        illegalQ <= illegalReq;
                        cntQ     <= 2'd1;
                    end
                end
                EXEC: begin
                    if (!bus.start) begin
                        stateQ <= IDLE;
                        busyQ  <= 1'b0;
                    end else if (execComplete) begin
                        stateQ  <= DONE;
                        doneQ   <= 1'b1;
                        errQ    <= illegalQ;
                        resultQ <= resultD;
                    end else begin
                        cntQ <= cntQ + 2'd1;
                    end
                end
                DONE: begin
                    stateQ <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    if (!bus.start) begin
                        stateQ <= IDLE;
                        busyQ  <= 1'b0;
                    end
                end
                default: begin
                    stateQ <= IDLE;
                    busyQ  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.done   = doneQ;
    assign bus.err    = errQ;
    assign bus.busy   = busyQ;
    assign bus.result = resultQ;

endmodule
